// File: rtl/ctrl_pkt_initiator.sv
// Control-packet initiator: turns one poke/peek request into a 4-word fifo36
// command packet and collects the matching 4-word response (one in flight).
module ctrl_pkt_initiator #(
  parameter logic [31:0] SID       = 32'd20,
  parameter logic [15:0] TIMEOUT   = 16'd1023,
  parameter int unsigned SEQ_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_read,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_data,
  output logic [35:0] out_data,
  output logic        out_src_rdy,
  input  logic        out_dst_rdy,
  input  logic [35:0] in_data,
  input  logic        in_src_rdy,
  output logic        in_dst_rdy,
  output logic        done,
  output logic [31:0] rb_data,
  output logic [2:0]  err,
  output logic [15:0] stray_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DRAIN} state_t;

  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic [1:0]             idx_q, idx_d;
  logic [15:0]            tmo_q, tmo_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic                   is_read_q, is_read_d;
  logic [7:0]             addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   done_q, done_d;
  logic [31:0]            rb_data_q, rb_data_d;
  logic [2:0]             err_q, err_d;
  logic [2:0]             err_acc_q, err_acc_d;
  logic [31:0]            rb_acc_q, rb_acc_d;
  logic [15:0]            stray_q, stray_d;

  logic        out_fire, in_fire, in_sof, in_eof;
  logic        stray_inc, finish;
  logic [15:0] seq_ext;
  logic        unused_hi;

  assign seq_ext     = 16'(seq_q);
  assign in_sof      = in_data[32];
  assign in_eof      = in_data[33];
  assign unused_hi   = ^in_data[35:34];
  assign out_src_rdy = (state_q == S_SEND);
  assign in_dst_rdy  = (state_q != S_SEND);
  // done cycle already sits in IDLE, but the next request waits one more cycle
  assign req_ready   = (state_q == S_IDLE) && !done_q;
  assign out_fire    = out_src_rdy && out_dst_rdy;
  assign in_fire     = in_src_rdy && in_dst_rdy;
  assign done        = done_q;
  assign rb_data     = rb_data_q;
  assign err         = err_q;
  assign stray_cnt   = stray_q;

  always_comb begin
    out_data = '0;
    case (wcnt_q)
      2'd0:    out_data = {2'b00, 1'b0, 1'b1, seq_ext, 16'd4};
      2'd1:    out_data = {4'h0, SID};
      2'd2:    out_data = {4'h0, 3'b000, is_read_q, 20'h0, addr_q};
      default: out_data = {2'b00, 1'b1, 1'b0, (is_read_q ? 32'h0 : data_q)};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    seq_d     = seq_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    rb_data_d = rb_data_q;
    err_d     = err_q;
    err_acc_d = err_acc_q;
    rb_acc_d  = rb_acc_q;
    stray_d   = stray_q;
    stray_inc = 1'b0;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_fire) stray_inc = 1'b1;
        if (req_valid && req_ready) begin
          is_read_d = req_is_read;
          addr_d    = req_addr;
          data_d    = req_data;
          wcnt_d    = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (out_fire) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d   = S_WAIT;
            tmo_d     = '0;
            idx_d     = '0;
            err_acc_d = '0;
            rb_acc_d  = '0;
          end
        end
      end
      S_WAIT: begin
        if (in_fire) begin
          case (idx_q)
            2'd0: begin
              if (!in_sof) begin
                stray_inc = 1'b1;
              end else begin
                if (in_data[31:16] != seq_ext) err_acc_d[2] = 1'b1;
                idx_d = 2'd1;
                if (in_eof) begin
                  err_acc_d[1] = 1'b1;
                  finish       = 1'b1;
                end
              end
            end
            2'd1: begin
              if (in_data[31:0] != SID) err_acc_d[1] = 1'b1;
              idx_d = 2'd2;
              if (in_eof) begin
                err_acc_d[1] = 1'b1;
                finish       = 1'b1;
              end
            end
            2'd2: begin
              idx_d = 2'd3;
              if (in_eof) begin
                err_acc_d[1] = 1'b1;
                finish       = 1'b1;
              end
            end
            default: begin
              rb_acc_d = in_data[31:0];
              if (in_eof) begin
                finish = 1'b1;
              end else begin
                err_acc_d[1] = 1'b1;
                state_d      = S_DRAIN;
              end
            end
          endcase
        end else if (idx_q == 2'd0) begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TIMEOUT) begin
            err_acc_d = 3'b001;
            rb_acc_d  = '1;
            finish    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (in_fire && in_eof) finish = 1'b1;
      end
    endcase

    if (finish) begin
      done_d    = 1'b1;
      err_d     = err_acc_d;
      rb_data_d = rb_acc_d;
      seq_d     = seq_q + SEQ_ONE;
      state_d   = S_IDLE;
    end

    if (stray_inc && (stray_q != 16'hFFFF)) stray_d = stray_q + 16'd1;

    // abort overrides any completion in the same cycle; results stay as they were
    if (clear) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      err_d     = err_q;
      rb_data_d = rb_data_q;
      seq_d     = ((state_q == S_WAIT) || (state_q == S_DRAIN)) ? (seq_q + SEQ_ONE) : seq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      seq_q     <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      rb_data_q <= '0;
      err_q     <= '0;
      err_acc_q <= '0;
      rb_acc_q  <= '0;
      stray_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      seq_q     <= seq_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      rb_data_q <= rb_data_d;
      err_q     <= err_d;
      err_acc_q <= err_acc_d;
      rb_acc_q  <= rb_acc_d;
      stray_q   <= stray_d;
    end
  end

endmodule

// File: tb/tb_ctrl_pkt_initiator.sv
// Scoreboard bench for ctrl_pkt_initiator: directed requests push expected
// command words and completions; a negedge monitor pops and compares them.
module tb_ctrl_pkt_initiator;

  localparam logic [31:0] SID = 32'd20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_read = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [35:0] out_data;
  logic        out_src_rdy;
  logic        out_dst_rdy = 1'b1;
  logic [35:0] in_data = '0;
  logic        in_src_rdy = 1'b0;
  logic        in_dst_rdy;
  logic        done;
  logic [31:0] rb_data;
  logic [2:0]  err;
  logic [15:0] stray_cnt;

  ctrl_pkt_initiator #(.SID(32'd20), .TIMEOUT(16'd1023), .SEQ_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_read(req_is_read),
    .req_addr(req_addr), .req_data(req_data),
    .out_data(out_data), .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .in_data(in_data), .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .done(done), .rb_data(rb_data), .err(err), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rb;
    logic [2:0]  err;
    bit          chk_rb;
  } done_t;

  logic [35:0] exp_out[$];
  done_t       exp_done[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] hdr(input int unsigned s);
    logic [15:0] s16;
    s16 = s[15:0];
    return {4'h1, s16, 16'd4};
  endfunction

  function automatic logic [35:0] body(input logic [31:0] d);
    return {4'h0, d};
  endfunction

  function automatic logic [35:0] last(input logic [31:0] d);
    return {4'h2, d};
  endfunction

  // monitor: scoreboard pops plus hold-while-stalled check
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [35:0] prev_d = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_v && !prev_r && out_src_rdy) chk("out_hold", 64'(out_data), 64'(prev_d));
      if (out_src_rdy && out_dst_rdy) begin
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_word unexpected act=%h exp=none", out_data);
        end else begin
          chk("out_word", 64'(out_data), 64'(exp_out.pop_front()));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done unexpected act=1 exp=0");
        end else begin
          done_t e;
          e = exp_done.pop_front();
          chk("done_err", 64'(err), 64'(e.err));
          if (e.chk_rb) chk("done_rb", 64'(rb_data), 64'(e.rb));
        end
      end
    end
    prev_v = out_src_rdy;
    prev_r = out_dst_rdy;
    prev_d = out_data;
  end

  task automatic issue(input logic rd, input logic [7:0] a, input logic [31:0] d);
    exp_out.push_back(hdr(exp_seq));
    exp_out.push_back(body(SID));
    exp_out.push_back(body({3'b000, rd, 20'h0, a}));
    exp_out.push_back(last(rd ? 32'h0 : d));
    chk("req_ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_is_read = rd; req_addr = a; req_data = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_send(output int n);
    n = 0;
    while (out_src_rdy && n < 50) begin tick(); n++; end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_word(input logic [35:0] w);
    in_data = w; in_src_rdy = 1'b1;
    tick();
    in_src_rdy = 1'b0;
  endtask

  task automatic expect_done(input logic [31:0] rb, input logic [2:0] e, input bit crb);
    done_t x;
    x.rb = rb; x.err = e; x.chk_rb = crb;
    exp_done.push_back(x);
  endtask

  task automatic after_final();
    chk("done_latency", 64'(done), 64'd1);
    chk("req_ready_at_done", 64'(req_ready), 64'd0);
    tick();
    chk("req_ready_after_done", 64'(req_ready), 64'd1);
    exp_seq++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_out_src_rdy", 64'(out_src_rdy), 64'd0);
    chk("rst_in_dst_rdy", 64'(in_dst_rdy), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rb", 64'(rb_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stray", 64'(stray_cnt), 64'd0);

    // poke, no backpressure
    issue(1'b0, 8'h21, 32'h1234_5678);
    chk("w0_latency", 64'(out_src_rdy), 64'd1);
    wait_send(n);
    chk("send_cycles", 64'(n), 64'd4);
    expect_done(32'hCAFE_0001, 3'b000, 1'b1);
    send_word(hdr(exp_seq)); send_word(body(SID)); send_word(body(32'h0));
    send_word(last(32'hCAFE_0001));
    after_final();

    // peek with downstream stalls
    issue(1'b1, 8'h5A, 32'hDEAD_BEEF);
    n = 0;
    while (out_src_rdy && n < 50) begin
      out_dst_rdy = pat[n % 4];
      tick(); n++;
    end
    out_dst_rdy = 1'b1;
    chk("stall_cycles", 64'(n), 64'd8);
    chk("stall_all_words", 64'(exp_out.size()), 64'd0);
    expect_done(32'hBEEF_0002, 3'b000, 1'b1);
    send_word(hdr(exp_seq)); send_word(body(SID)); send_word(body(32'h0));
    send_word(last(32'hBEEF_0002));
    after_final();

    // timeout
    issue(1'b0, 8'h10, 32'h0000_0001);
    wait_send(n);
    expect_done(32'hFFFF_FFFF, 3'b001, 1'b1);
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    chk("timeout_cycles", 64'(n), 64'd1023);
    chk("req_ready_at_tmo_done", 64'(req_ready), 64'd0);
    tick();
    chk("req_ready_after_tmo", 64'(req_ready), 64'd1);
    exp_seq++;

    // header seq mismatch
    issue(1'b1, 8'h01, 32'h0);
    wait_send(n);
    expect_done(32'h0000_0A0A, 3'b100, 1'b1);
    send_word(hdr(5)); send_word(body(SID)); send_word(body(32'h0));
    send_word(last(32'h0000_0A0A));
    after_final();

    // SID mismatch
    issue(1'b1, 8'h02, 32'h0);
    wait_send(n);
    expect_done(32'h0000_0B0B, 3'b010, 1'b1);
    send_word(hdr(exp_seq)); send_word(body(32'd21)); send_word(body(32'h0));
    send_word(last(32'h0000_0B0B));
    after_final();

    // early EOF on word 1
    issue(1'b1, 8'h03, 32'h0);
    wait_send(n);
    expect_done(32'h0, 3'b010, 1'b0);
    send_word(hdr(exp_seq)); send_word(last(SID));
    after_final();

    // over-long response, drained to EOF
    issue(1'b1, 8'h04, 32'h0);
    wait_send(n);
    expect_done(32'h1111_2222, 3'b010, 1'b1);
    send_word(hdr(exp_seq)); send_word(body(SID)); send_word(body(32'h0));
    send_word(body(32'h1111_2222)); send_word(body(32'h5));
    chk("no_done_in_drain", 64'(done), 64'd0);
    send_word(last(32'h6));
    after_final();

    // stray words while idle
    chk("stray_before", 64'(stray_cnt), 64'd0);
    send_word(hdr(0)); send_word(body(32'h7)); send_word(last(32'h8));
    tick();
    chk("stray_after", 64'(stray_cnt), 64'd3);

    // reset mid-SEND after w1
    issue(1'b0, 8'h33, 32'h3333_3333);
    void'(exp_out.pop_back());
    void'(exp_out.pop_back());
    tick(); tick();
    out_dst_rdy = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; out_dst_rdy = 1'b1;
    chk("reset_out_src_rdy", 64'(out_src_rdy), 64'd0);
    chk("reset_stray", 64'(stray_cnt), 64'd0);
    exp_seq = 0;
    tick();

    // clear during WAIT: seq advances, no done
    issue(1'b0, 8'h44, 32'h4444_4444);
    wait_send(n);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_req_ready", 64'(req_ready), 64'd1);
    chk("clear_no_done", 64'(done), 64'd0);
    chk("clear_in_dst_rdy", 64'(in_dst_rdy), 64'd1);
    exp_seq++;

    issue(1'b0, 8'h55, 32'h5555_5555);
    wait_send(n);
    expect_done(32'h0000_5A5A, 3'b000, 1'b1);
    send_word(hdr(exp_seq)); send_word(body(SID)); send_word(body(32'h0));
    send_word(last(32'h0000_5A5A));
    after_final();

    tick(); tick();
    chk("out_queue_empty", 64'(exp_out.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
